jtdsp16_do_ctrl: RTL and testbench

- Sequences the hardware do-loop cache of the ROM address unit (XAAU).
- Decodes an accepted `do K {NI}` or `redo K` instruction and drives the XAAU loop controls: do_start, do_redo, do_save, do_short, do_pc and do_out.
- Counts instruction offset and remaining iterations.
- Holds off interrupts while a loop runs.

---
 rtl/jtdsp16_do_ctrl.sv | 113 +++++++++++
 tb/tb_jtdsp16_do_ctrl.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/jtdsp16_do_ctrl.sv
// Do-loop cache sequencer for the JTDSP16 ROM address unit: accepts do/redo,
// counts block offset and iterations. Define JTDSP16_DO_DEBUG_EN to expose the loop counters.
module jtdsp16_do_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        cen,
  input  logic        do_en,
  input  logic [10:0] do_data,
  input  logic        hold,
  output logic        do_start,
  output logic        do_redo,
  output logic        do_save,
  output logic        do_short,
  output logic [3:0]  do_pc,
  output logic        do_out,
  output logic        busy,
  output logic        no_int,
  output logic        nest_err,
  output logic [6:0]  debug_k,
  output logic [3:0]  debug_ni
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t      state_q;
  logic [3:0]  ni_q;
  logic [6:0]  k_q;
  logic [3:0]  pc_q;

  logic [3:0]  ni_in;
  logic [6:0]  k_in;
  logic        is_redo;
  logic [3:0]  ni_d;
  logic        idle;
  logic        issue;
  logic        accept;
  logic        step;
  logic        blk_end;
  logic        last_k;

  assign ni_in   = do_data[10:7];
  assign k_in    = do_data[6:0];
  assign is_redo = (ni_in == 4'd0);
  // A redo reuses the length stored by the last do.
  assign ni_d    = is_redo ? ni_q : ni_in;
  assign idle    = (state_q == IDLE);
  assign busy    = (state_q == RUN);

  // Combinational outputs are masked during reset so the block is silent immediately.
  assign issue   = !rst && cen && do_en && !hold;
  assign accept  = issue && idle && (ni_d != 4'd0) && (k_in != 7'd0);
  assign step    = !rst && cen && !hold && busy;
  assign blk_end = (pc_q == ni_q - 4'd1);
  assign last_k  = (k_q == 7'd1);

  assign do_start = accept;
  assign do_redo  = accept && is_redo;
  assign do_save  = accept && !is_redo;
  assign do_short = accept ? (ni_d == 4'd1) : (busy && (ni_q == 4'd1));
  assign do_pc    = pc_q;
  assign do_out   = step && blk_end && last_k;
  assign no_int   = busy || do_start;
  assign nest_err = issue && (busy ||
                    (idle && is_redo && (ni_q == 4'd0) && (k_in != 7'd0)));

  // NOTE: sequential state uses non-blocking assignments only; the async reset
  // clears the stored block length too, so a redo after reset is rejected.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      ni_q    <= 4'd0;
      k_q     <= 7'd0;
      pc_q    <= 4'd0;
    end else if (cen && !hold) begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            ni_q    <= ni_d;
            k_q     <= k_in;
            pc_q    <= 4'd0;
            state_q <= RUN;
          end
        end
        RUN: begin
          if (blk_end) begin
            pc_q <= 4'd0;
            if (last_k) begin
              k_q     <= 7'd0;
              state_q <= IDLE;
            end else begin
              k_q <= k_q - 7'd1;
            end
          end else begin
            pc_q <= pc_q + 4'd1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef JTDSP16_DO_DEBUG_EN
  assign debug_k  = k_q;
  assign debug_ni = ni_q;
`else
  assign debug_k  = 7'd0;
  assign debug_ni = 4'd0;
`endif

endmodule

// File: tb/tb_jtdsp16_do_ctrl.sv
// Scoreboard bench for jtdsp16_do_ctrl: the driver queues the expected output
// snapshot of every cycle, a monitor on the falling edge pops and compares it.
module tb_jtdsp16_do_ctrl;

  logic        clk = 1'b1;
  logic        rst;
  logic        cen;
  logic        do_en;
  logic [10:0] do_data;
  logic        hold;
  logic        do_start, do_redo, do_save, do_short, do_out, busy, no_int, nest_err;
  logic [3:0]  do_pc;
  logic [6:0]  debug_k;
  logic [3:0]  debug_ni;

  typedef struct packed {
    logic       start;
    logic       redo;
    logic       save;
    logic       shrt;
    logic [3:0] pc;
    logic       out;
    logic       busy;
    logic       no_int;
    logic       nerr;
    logic [6:0] dk;
    logic [3:0] dni;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   ni_m  = 0;   // block length the DUT should currently hold

  jtdsp16_do_ctrl dut (
    .clk(clk), .rst(rst), .cen(cen), .do_en(do_en), .do_data(do_data), .hold(hold),
    .do_start(do_start), .do_redo(do_redo), .do_save(do_save), .do_short(do_short),
    .do_pc(do_pc), .do_out(do_out), .busy(busy), .no_int(no_int), .nest_err(nest_err),
    .debug_k(debug_k), .debug_ni(debug_ni)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  function automatic logic [6:0] dbg_k(input int v);
`ifdef JTDSP16_DO_DEBUG_EN
    return 7'(v);
`else
    return 7'd0 + 7'(v * 0);
`endif
  endfunction

  function automatic logic [3:0] dbg_ni(input int v);
`ifdef JTDSP16_DO_DEBUG_EN
    return 4'(v);
`else
    return 4'd0 + 4'(v * 0);
`endif
  endfunction

  function automatic exp_t e_idle();
    exp_t x = '0;
    x.dni = dbg_ni(ni_m);
    return x;
  endfunction

  function automatic exp_t e_nerr();
    exp_t x = e_idle();
    x.nerr = 1'b1;
    return x;
  endfunction

  // Accept cycle: counters not yet loaded, remaining count is 0 after any exit.
  function automatic exp_t e_acc(input logic redo, input logic shrt);
    exp_t x = e_idle();
    x.start  = 1'b1;
    x.redo   = redo;
    x.save   = !redo;
    x.shrt   = shrt;
    x.no_int = 1'b1;
    return x;
  endfunction

  function automatic exp_t e_run(input int pc, input logic out, input logic shrt, input int k);
    exp_t x = '0;
    x.pc     = 4'(pc);
    x.out    = out;
    x.shrt   = shrt;
    x.busy   = 1'b1;
    x.no_int = 1'b1;
    x.dk     = dbg_k(k);
    x.dni    = dbg_ni(ni_m);
    return x;
  endfunction

  // One clock cycle: drive inputs, queue the expected snapshot, advance past the edge.
  task automatic cyc(input logic r, input logic c, input logic e, input logic [3:0] ni,
                     input logic [6:0] k, input logic h, input exp_t x);
    rst = r; cen = c; do_en = e; do_data = {ni, k}; hold = h;
    sb.push_back(x);
    @(posedge clk);
    #1;
  endtask

  // Expected uninterrupted run: offset walks 0..ni-1, K counts down per block.
  task automatic run_loop(input int ni, input int k);
    for (int i = 0; i < ni * k; i++)
      cyc(0, 1, 0, 0, 0, 0, e_run(i % ni, i == ni * k - 1, ni == 1, k - i / ni));
  endtask

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t x;
      x = sb.pop_front();
      check("do_start", 32'(do_start), 32'(x.start));
      check("do_redo",  32'(do_redo),  32'(x.redo));
      check("do_save",  32'(do_save),  32'(x.save));
      check("do_short", 32'(do_short), 32'(x.shrt));
      check("do_pc",    32'(do_pc),    32'(x.pc));
      check("do_out",   32'(do_out),   32'(x.out));
      check("busy",     32'(busy),     32'(x.busy));
      check("no_int",   32'(no_int),   32'(x.no_int));
      check("nest_err", 32'(nest_err), 32'(x.nerr));
      check("debug_k",  32'(debug_k),  32'(x.dk));
      check("debug_ni", 32'(debug_ni), 32'(x.dni));
    end
  end

  initial begin
    // Reset state
    ni_m = 0;
    cyc(1, 0, 0, 0, 0, 0, e_idle());
    cyc(1, 1, 1, 4'd3, 7'd2, 0, e_idle());
    cyc(0, 1, 0, 0, 0, 0, e_idle());

    // Basic do {3,2}, then back-to-back redo {0,3}
    cyc(0, 1, 1, 4'd3, 7'd2, 0, e_acc(0, 0));
    ni_m = 3;
    run_loop(3, 2);
    cyc(0, 1, 1, 4'd0, 7'd3, 0, e_acc(1, 0));
    run_loop(3, 3);
    cyc(0, 1, 0, 0, 0, 0, e_idle());

    // Short loop {1,4}
    cyc(0, 1, 1, 4'd1, 7'd4, 0, e_acc(0, 1));
    ni_m = 1;
    run_loop(1, 4);
    cyc(0, 1, 0, 0, 0, 0, e_idle());

    // Stall {2,2}: hold three cycles at offset 1 of the first pass
    cyc(0, 1, 1, 4'd2, 7'd2, 0, e_acc(0, 0));
    ni_m = 2;
    cyc(0, 1, 0, 0, 0, 0, e_run(0, 0, 0, 2));
    for (int i = 0; i < 3; i++) cyc(0, 1, 0, 0, 0, 1, e_run(1, 0, 0, 2));
    cyc(0, 1, 0, 0, 0, 0, e_run(1, 0, 0, 2));
    cyc(0, 1, 0, 0, 0, 0, e_run(0, 0, 0, 1));
    cyc(0, 1, 0, 0, 0, 0, e_run(1, 1, 0, 1));
    cyc(0, 1, 0, 0, 0, 0, e_idle());

    // Clock-enable gaps on a redo {0,2}, including on the final instruction
    cyc(0, 1, 1, 4'd0, 7'd2, 0, e_acc(1, 0));
    cyc(0, 1, 0, 0, 0, 0, e_run(0, 0, 0, 2));
    for (int i = 0; i < 2; i++) cyc(0, 0, 0, 0, 0, 0, e_run(1, 0, 0, 2));
    cyc(0, 1, 0, 0, 0, 0, e_run(1, 0, 0, 2));
    cyc(0, 1, 0, 0, 0, 0, e_run(0, 0, 0, 1));
    cyc(0, 0, 0, 0, 0, 0, e_run(1, 0, 0, 1));
    cyc(0, 1, 0, 0, 0, 0, e_run(1, 1, 0, 1));
    cyc(0, 0, 1, 4'd3, 7'd2, 0, e_idle());
    cyc(0, 1, 0, 0, 0, 0, e_idle());

    // Errors: redo after reset, K=0, nested do
    ni_m = 0;
    cyc(1, 1, 0, 0, 0, 0, e_idle());
    cyc(0, 1, 1, 4'd0, 7'd3, 0, e_nerr());
    cyc(0, 1, 0, 0, 0, 0, e_idle());
    cyc(0, 1, 1, 4'd3, 7'd0, 0, e_idle());
    cyc(0, 1, 1, 4'd2, 7'd2, 0, e_acc(0, 0));
    ni_m = 2;
    cyc(0, 1, 0, 0, 0, 0, e_run(0, 0, 0, 2));
    begin
      exp_t x;
      x = e_run(1, 0, 0, 2);
      x.nerr = 1'b1;
      cyc(0, 1, 1, 4'd5, 7'd5, 0, x);
    end
    cyc(0, 1, 0, 0, 0, 0, e_run(0, 0, 0, 1));
    cyc(0, 1, 0, 0, 0, 0, e_run(1, 1, 0, 1));
    cyc(0, 1, 0, 0, 0, 0, e_idle());

    // Reset mid-loop at offset 2 of {4,5}; a following redo is an error
    cyc(0, 1, 1, 4'd4, 7'd5, 0, e_acc(0, 0));
    ni_m = 4;
    cyc(0, 1, 0, 0, 0, 0, e_run(0, 0, 0, 5));
    cyc(0, 1, 0, 0, 0, 0, e_run(1, 0, 0, 5));
    ni_m = 0;
    cyc(1, 1, 0, 0, 0, 0, e_idle());
    cyc(0, 1, 0, 0, 0, 0, e_idle());
    cyc(0, 1, 1, 4'd0, 7'd3, 0, e_nerr());
    cyc(0, 1, 0, 0, 0, 0, e_idle());

    // Let the monitor drain the queue, bounded
    for (int i = 0; i < 5 && sb.size() > 0; i++) @(posedge clk);
    check("sb_drain", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
